// File: rtl/recompute_corrector.sv
// rtl/recompute_corrector.sv - adds buffered recompute products into bypassed columns of the array output
// Define RC_SATURATE_EN to clamp corrected column sums instead of wrapping.
module recompute_corrector #(
  parameter int WORD_SIZE  = 16,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rc_valid,
  output logic                      rc_ready,
  input  logic [WORD_SIZE-1:0]      rc_product,
  input  logic [ROWS-1:0]           rc_row,
  input  logic [COLS-1:0]           rc_col,
  input  logic                      fault_active,
  input  logic                      arr_valid,
  output logic                      arr_ready,
  input  logic [COLS*WORD_SIZE-1:0] arr_psum,
  output logic                      out_valid,
  output logic [COLS*WORD_SIZE-1:0] out_psum,
  output logic [ROWS-1:0]           out_fault_row,
  output logic                      err_overflow,
  output logic                      err_timeout
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, STALL} state_t;

  logic [WORD_SIZE-1:0] prod_mem [FIFO_DEPTH];
  logic [ROWS-1:0]      row_mem  [FIFO_DEPTH];
  logic [COLS-1:0]      col_mem  [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          empty, full, push, pop;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, correct, set_timeout, timed_out;

  logic                      out_valid_q, err_ov_q, err_to_q;
  logic [COLS*WORD_SIZE-1:0] out_psum_q, corr_psum;
  logic [ROWS-1:0]           out_row_q;

  logic [WORD_SIZE-1:0] head_prod;
  logic [ROWS-1:0]      head_row;
  logic [COLS-1:0]      head_col;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign rc_ready = ~full;
  assign push     = rc_valid & ~full;
  assign pop      = correct;

  assign head_prod = prod_mem[rd_ptr_q];
  assign head_row  = row_mem[rd_ptr_q];
  assign head_col  = col_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      prod_mem[wr_ptr_q] <= rc_product;
      row_mem[wr_ptr_q]  <= rc_row;
      col_mem[wr_ptr_q]  <= rc_col;
    end
  end

  // The vector is held back only while a correction is owed and nothing is buffered to apply.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    correct     = 1'b0;
    set_timeout = 1'b0;
    timed_out   = (state_q == STALL) && (cnt_q == CW'(TIMEOUT));
    if (arr_valid) begin
      if (!fault_active || !empty) begin
        accept  = 1'b1;
        correct = fault_active;
        state_d = IDLE;
      end else if (timed_out) begin
        accept      = 1'b1;
        set_timeout = 1'b1;
        state_d     = IDLE;
      end else begin
        state_d = STALL;
        cnt_d   = (state_q == IDLE) ? '0 : cnt_q + CW'(1);
      end
    end else begin
      state_d = IDLE;
    end
  end

  assign arr_ready = accept | ~arr_valid;

  always_comb begin
    corr_psum = arr_psum;
    for (int c = 0; c < COLS; c++) begin
      if (correct && head_col[c]) begin
`ifdef RC_SATURATE_EN
        logic [WORD_SIZE:0] sum;
        sum = {1'b0, arr_psum[c*WORD_SIZE +: WORD_SIZE]} + {1'b0, head_prod};
        corr_psum[c*WORD_SIZE +: WORD_SIZE] = sum[WORD_SIZE] ? '1 : sum[WORD_SIZE-1:0];
`else
        corr_psum[c*WORD_SIZE +: WORD_SIZE] = arr_psum[c*WORD_SIZE +: WORD_SIZE] + head_prod;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_psum_q  <= '0;
      out_row_q   <= '0;
      err_ov_q    <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      out_valid_q <= accept;
      if (accept) begin
        out_psum_q <= corr_psum;
        out_row_q  <= (correct && (head_col != '0)) ? head_row : '0;
      end
      if (rc_valid && full) err_ov_q <= 1'b1;
      if (set_timeout)      err_to_q <= 1'b1;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_psum      = out_psum_q;
  assign out_fault_row = out_row_q;
  assign err_overflow  = err_ov_q;
  assign err_timeout   = err_to_q;

endmodule

// File: tb/tb_recompute_corrector.sv
// tb/tb_recompute_corrector.sv - scoreboard bench for recompute_corrector against a queue-based reference
module tb_recompute_corrector;
  localparam int W  = 16;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int D  = 4;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic           rc_valid, rc_ready;
  logic [W-1:0]   rc_product;
  logic [R-1:0]   rc_row;
  logic [C-1:0]   rc_col;
  logic           fault_active, arr_valid, arr_ready;
  logic [C*W-1:0] arr_psum, out_psum;
  logic           out_valid;
  logic [R-1:0]   out_fault_row;
  logic           err_overflow, err_timeout;

  always #5 clk = ~clk;

  recompute_corrector #(.WORD_SIZE(W), .ROWS(R), .COLS(C), .FIFO_DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rc_valid(rc_valid), .rc_ready(rc_ready), .rc_product(rc_product),
    .rc_row(rc_row), .rc_col(rc_col), .fault_active(fault_active),
    .arr_valid(arr_valid), .arr_ready(arr_ready), .arr_psum(arr_psum),
    .out_valid(out_valid), .out_psum(out_psum), .out_fault_row(out_fault_row),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  typedef struct { logic [W-1:0] prod; logic [R-1:0] row; logic [C-1:0] col; } rc_t;
  typedef struct { logic [C*W-1:0] psum; logic [R-1:0] row; } exp_t;

  rc_t  mfifo[$];
  exp_t expq[$];
  exp_t mon_e;
  int   n_pass = 0, n_total = 0;
  int   wait_n = 0;
  bit   m_ov = 0, m_to = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] col_add(input logic [W-1:0] a, input logic [W-1:0] p);
    longint s;
    s = longint'(a) + longint'(p);
`ifdef RC_SATURATE_EN
    return (s > 65535) ? 16'hFFFF : W'(s);
`else
    return W'(s % 65536);
`endif
  endfunction

  // One clock of stimulus: inputs are already driven; predict, then check the registered results.
  task automatic step(output bit acc);
    bit   m_full, m_empty, timed;
    rc_t  h, n;
    exp_t e;
    @(negedge clk);
    m_empty = (mfifo.size() == 0);
    m_full  = (mfifo.size() == D);
    timed   = (wait_n == TO + 1);
    acc     = arr_valid && (!fault_active || !m_empty || timed);
    chk("rc_ready", rc_ready, !m_full);
    chk("arr_ready", arr_ready, acc || !arr_valid);
    if (acc) begin
      e.psum = arr_psum;
      e.row  = '0;
      if (fault_active && !m_empty) begin
        h = mfifo.pop_front();
        for (int c = 0; c < C; c++)
          if (h.col[c]) e.psum[c*W +: W] = col_add(arr_psum[c*W +: W], h.prod);
        if (h.col != 0) e.row = h.row;
      end else if (fault_active) begin
        m_to = 1;
      end
      expq.push_back(e);
      wait_n = 0;
    end else if (arr_valid) wait_n++;
    else wait_n = 0;
    if (rc_valid && !m_full) begin
      n.prod = rc_product; n.row = rc_row; n.col = rc_col;
      mfifo.push_back(n);
    end
    if (rc_valid && m_full) m_ov = 1;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, acc);
    chk("err_overflow", err_overflow, m_ov);
    chk("err_timeout", err_timeout, m_to);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; arr_valid = 1'b0; rc_valid = 1'b0; fault_active = 1'b0;
    mfifo.delete(); expq.delete();
    wait_n = 0; m_ov = 0; m_to = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_psum", out_psum, 0);
    chk("rst_out_row", out_fault_row, 0);
    chk("rst_err_ov", err_overflow, 0);
    chk("rst_err_to", err_timeout, 0);
    chk("rst_rc_ready", rc_ready, 1);
    chk("rst_arr_ready", arr_ready, 1);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (expq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got %h expected none", out_psum);
      end else begin
        mon_e = expq.pop_front();
        chk("out_psum", out_psum, mon_e.psum);
        chk("out_fault_row", out_fault_row, mon_e.row);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit acc;
    int low;
    rst = 1'b1; rc_valid = 1'b0; rc_product = '0; rc_row = '0; rc_col = '0;
    fault_active = 1'b0; arr_valid = 1'b0; arr_psum = '0;
    do_reset();

    // Plain pass-through
    arr_valid = 1; fault_active = 0; arr_psum = 64'h0010_0010_0010_0010;
    step(acc);
    chk("passthru_psum", out_psum, 64'h0010_0010_0010_0010);
    chk("passthru_row", out_fault_row, 0);
    arr_valid = 0;

    // Single correction into column 2
    rc_valid = 1; rc_product = 16'h0006; rc_row = 4'b0010; rc_col = 4'b0100;
    step(acc);
    rc_valid = 0; arr_valid = 1; fault_active = 1;
    step(acc);
    chk("corr_psum", out_psum, 64'h0010_0016_0010_0010);
    chk("corr_row", out_fault_row, 4'b0010);

    // Stall three cycles, product arrives on the third
    step(acc); chk("stall1", acc, 0);
    step(acc); chk("stall2", acc, 0);
    rc_valid = 1; rc_product = 16'h0005; rc_row = 4'b0001; rc_col = 4'b0001;
    step(acc); chk("stall3", acc, 0);
    rc_valid = 0;
    step(acc); chk("stall_release", acc, 1);
    chk("stall_psum", out_psum, 64'h0010_0010_0010_0015);
    arr_valid = 0;
    step(acc);

    // Timeout with nothing buffered
    arr_valid = 1; fault_active = 1; arr_psum = 64'h1111_2222_3333_4444;
    low = 0; acc = 0;
    while (!acc && low < 40) begin
      step(acc);
      if (!acc) low++;
    end
    chk("timeout_wait", low, TO + 1);
    chk("timeout_psum", out_psum, 64'h1111_2222_3333_4444);
    chk("timeout_flag", err_timeout, 1);
    arr_valid = 0;
    repeat (3) step(acc);
    do_reset();

    // Overflow: five pushes into a depth-4 buffer
    for (int i = 0; i < 5; i++) begin
      rc_valid = 1; rc_product = 16'(i + 1); rc_row = 4'b1000; rc_col = 4'(1 << (i % 4));
      step(acc);
    end
    rc_valid = 0;
    chk("overflow_flag", err_overflow, 1);
    chk("overflow_full", rc_ready, 0);
    arr_valid = 1; fault_active = 1;
    for (int i = 0; i < 4; i++) begin
      arr_psum = {$urandom(), $urandom()};
      step(acc);
      chk("drain_accept", acc, 1);
    end
    step(acc);
    chk("fifth_dropped", acc, 0);
    do_reset();

    // Wrap / saturate boundary
    rc_valid = 1; rc_product = 16'h0005; rc_row = 4'b0100; rc_col = 4'b0001;
    step(acc);
    rc_valid = 0; arr_valid = 1; fault_active = 1; arr_psum = 64'h0000_0000_0000_FFFE;
    step(acc);
`ifdef RC_SATURATE_EN
    chk("boundary_col0", out_psum[15:0], 16'hFFFF);
`else
    chk("boundary_col0", out_psum[15:0], 16'h0003);
`endif
    arr_valid = 0;
    step(acc);

    // Reset in the middle of a stall, with a product arriving alongside it
    arr_valid = 1; fault_active = 1;
    repeat (4) step(acc);
    rc_valid = 1; rc_product = 16'h0009; rc_row = 4'b0001; rc_col = 4'b0010;
    do_reset();
    arr_valid = 1; fault_active = 1;
    step(acc);
    chk("post_rst_discarded", acc, 0);
    arr_valid = 0;
    step(acc);

    // Randomized traffic
    for (int v = 0; v < 300; v++) begin
      fault_active = 1'($urandom_range(0, 1));
      arr_psum = {$urandom(), $urandom()};
      arr_valid = 1;
      acc = 0;
      for (int t = 0; t < 40 && !acc; t++) begin
        rc_valid   = ($urandom_range(0, 9) < 4);
        rc_product = 16'($urandom());
        rc_row     = 4'(1 << $urandom_range(0, 3));
        rc_col     = ($urandom_range(0, 7) == 0) ? 4'b0 : 4'(1 << $urandom_range(0, 3));
        step(acc);
      end
      if (!acc) chk("handshake_bound", 0, 1);
      arr_valid = 0;
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        rc_valid   = ($urandom_range(0, 9) < 4);
        rc_product = 16'($urandom());
        rc_row     = 4'(1 << $urandom_range(0, 3));
        rc_col     = 4'(1 << $urandom_range(0, 3));
        step(acc);
      end
    end
    rc_valid = 0; arr_valid = 0;
    repeat (2) step(acc);
    chk("scoreboard_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/recompute_corrector.md
RECOMPUTE_CORRECTOR -- requirements
Module: recompute_corrector

Interface
REQ-001 Parameter WORD_SIZE, default 16, SHALL set the bit width of a product and of each column partial sum.
REQ-002 Parameter ROWS, default 4, SHALL set the width of the one-hot faulty-row tag.
REQ-003 Parameter COLS, default 4, SHALL set the number of array columns and the width of the one-hot faulty-column tag.
REQ-004 Parameter FIFO_DEPTH, default 4 (power of 2), SHALL set the number of product-buffer entries.
REQ-005 Parameter TIMEOUT, default 15, SHALL set the maximum number of stall cycles before uncorrected pass-through.
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-008 rc_valid  input  1  SHALL be high when a recompute product is presented.
REQ-009 rc_ready  output  1  SHALL be high when the product FIFO can accept an entry.
REQ-010 rc_product  input  WORD_SIZE  SHALL carry the recomputed Weight*LeftIn product.
REQ-011 rc_row  input  ROWS  SHALL carry the one-hot faulty-row tag of that product.
REQ-012 rc_col  input  COLS  SHALL carry the one-hot faulty-column tag of that product.
REQ-013 fault_active  input  1  SHALL be high when a faulty PE is bypassed and correction is required.
REQ-014 arr_valid  input  1  SHALL be high when the array presents a bottom-row partial-sum vector.
REQ-015 arr_ready  output  1  SHALL be high when the block accepts arr_psum.
REQ-016 arr_psum  input  COLS*WORD_SIZE  SHALL carry the column partial sums, column c in bits [c*WORD_SIZE +: WORD_SIZE].
REQ-017 out_valid  output  1  SHALL pulse high for one cycle per emitted vector.
REQ-018 out_psum  output  COLS*WORD_SIZE  SHALL carry the corrected partial sums.
REQ-019 out_fault_row  output  ROWS  SHALL carry the rc_row tag applied to the current output, zero if none.
REQ-020 err_overflow  output  1  SHALL be a sticky flag: rc_valid seen while rc_ready low.
REQ-021 err_timeout  output  1  SHALL be a sticky flag: a stall reached TIMEOUT.

Function
REQ-022 rc_ready SHALL equal NOT full; a push SHALL occur only on rc_valid AND rc_ready; a rejected product SHALL be dropped.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL track simultaneous push and pop without change.
REQ-024 State machine SHALL have states IDLE, STALL; reset state IDLE.
REQ-025 IDLE, arr_valid, fault_active low: arr_ready high; out_psum SHALL be arr_psum unchanged, out_fault_row zero, no pop.
REQ-026 IDLE, arr_valid, fault_active high, FIFO non-empty: arr_ready high; pop head; for each column c with rc_col[c] set, out_psum column c SHALL be arr_psum column c plus rc_product; other columns unchanged.
REQ-027 IDLE, arr_valid, fault_active high, FIFO empty: arr_ready low; go to STALL; stall counter cleared.
REQ-028 STALL: arr_ready low while FIFO empty and counter below TIMEOUT; counter increments each cycle.
REQ-029 STALL, FIFO non-empty: apply REQ-026 that cycle; return to IDLE.
REQ-030 STALL, counter reaches TIMEOUT with FIFO empty: arr_ready high; emit uncorrected per REQ-025; set err_timeout; return to IDLE.
REQ-031 A head entry with rc_col zero SHALL be popped and emitted as pass-through.
REQ-032 Output latency SHALL be one cycle: out_valid, out_psum, out_fault_row registered on the cycle after acceptance.
REQ-033 Without saturation, addition SHALL wrap modulo 2^WORD_SIZE, unsigned.
REQ-034 A push landing in the same cycle as a stall SHALL become visible to the pop on the next cycle.

Reset
REQ-035 On rst: state IDLE, FIFO empty, stall counter 0, out_valid 0, out_psum 0, out_fault_row 0, err_overflow 0, err_timeout 0.
REQ-036 rst mid-stall SHALL discard buffered products and the pending vector; arr_ready SHALL be high on the cycle after rst falls.

Configuration
REQ-037 Macro RC_SATURATE_EN defined: corrected column sums SHALL clamp to 2^WORD_SIZE-1 on unsigned overflow.
REQ-038 Macro RC_SATURATE_EN undefined: sums SHALL wrap per REQ-033.

Verification
REQ-039 fault_active=0; arr_psum all columns 0x0010 -> next cycle out_valid=1, out_psum unchanged, out_fault_row=0.
REQ-040 Push product 0x0006, rc_col=0b0100, rc_row=0b0010; arr_psum columns 0x0010 -> out_psum col2=0x0016, others 0x0010, out_fault_row=0b0010.
REQ-041 FIFO empty, vector waits 3 cycles, product 0x0005 arrives -> arr_ready low 3 cycles, then col sum +5, err_timeout=0.
REQ-042 FIFO empty for 15 cycles -> uncorrected output, err_timeout=1 until rst.
REQ-043 Five pushes with no pops (depth 4) -> rc_ready low after 4, err_overflow=1, 5th dropped.
REQ-044 arr_psum col 0xFFFE + product 0x0005 -> 0x0003 without RC_SATURATE_EN, 0xFFFF with it.
